program_rom_loader: RTL and testbench

//  Write side of the program-ROM store. Takes the MiSTer HPS ioctl byte stream and writes it into the five 8 KB program ROM blocks (1F,1H,1K,1L,1N) that the CPU reads through the bank/ROM-select read path.

---
 rtl/program_rom_loader.sv | 163 ++++++++++++++++
 tb/tb_program_rom_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_rom_loader.sv
// Program-ROM download engine: turns the HPS ioctl byte stream into one-hot
// ROM block writes, holds the CPU in reset meanwhile and reports the outcome.
module program_rom_loader #(
    parameter int         ROM_AW     = 13,
    parameter int         NUM_ROMS   = 5,
    parameter logic [7:0] LOAD_INDEX = 8'd0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ioctl_download,
    input  logic [7:0]          ioctl_index,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic                ioctl_wr,
    output logic                ioctl_wait,
    output logic [ROM_AW-1:0]   rom_wr_addr,
    output logic [7:0]          rom_wr_data,
    output logic [NUM_ROMS-1:0] rom_we,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_error,
    output logic [15:0]         checksum
);

    localparam int          CHIP_W      = (NUM_ROMS > 1) ? $clog2(NUM_ROMS) : 1;
    localparam logic [24:0] IMAGE_BYTES = 25'(NUM_ROMS << ROM_AW);
    localparam logic [15:0] IMAGE_COUNT = 16'(NUM_ROMS << ROM_AW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ROM_AW-1:0]     addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic [NUM_ROMS-1:0]   we_q, we_d;
    logic                  wait_q, wait_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [15:0]           checksum_q, checksum_d;
    logic [15:0]           count_q, count_d;

    logic                  dl_active;
    logic                  addr_in_range;
    logic [CHIP_W-1:0]     chip;
    logic [NUM_ROMS-1:0]   chip_onehot;

    assign dl_active     = ioctl_download && (ioctl_index == LOAD_INDEX);
    assign addr_in_range = (ioctl_addr < IMAGE_BYTES);
    assign chip          = ioctl_addr[ROM_AW +: CHIP_W];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ROMS; gi++) begin : g_chip_dec
            assign chip_onehot[gi] = (chip == CHIP_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = '0;
        wait_d     = 1'b0;
        hold_d     = hold_q;
        done_d     = done_q;
        error_d    = error_q;
        checksum_d = checksum_q;
        count_d    = count_q;

        case (state_q)
            S_IDLE: begin
                if (dl_active) begin
                    state_d    = S_LOAD;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    checksum_d = '0;
                    count_d    = '0;
                    hold_d     = 1'b1;
                end
            end
            S_LOAD: begin
                if (!dl_active) begin
                    // Download finished: judge the image by byte count and error history.
                    state_d = S_DONE;
                    hold_d  = 1'b0;
                    if ((count_q == IMAGE_COUNT) && !error_q) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (ioctl_wr) begin
                    if (addr_in_range) begin
                        state_d = S_WRITE;
                        addr_d  = ioctl_addr[ROM_AW-1:0];
                        data_d  = ioctl_dout;
                        we_d    = chip_onehot;
                        wait_d  = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // Always finishes, even if the download has already dropped.
                state_d    = S_LOAD;
                checksum_d = checksum_q + {8'h00, data_q};
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
                if (ioctl_wr) begin
                    error_d = 1'b1;
                end
            end
            S_DONE: begin
                if (dl_active) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= '0;
            wait_q     <= 1'b0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            checksum_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            we_q       <= we_d;
            wait_q     <= wait_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
            checksum_q <= checksum_d;
            count_q    <= count_d;
        end
    end

    assign ioctl_wait  = wait_q;
    assign rom_wr_addr = addr_q;
    assign rom_wr_data = data_q;
    assign rom_we      = we_q;
    assign cpu_hold    = hold_q;
    assign load_done   = done_q;
    assign load_error  = error_q;
    assign checksum    = checksum_q;

endmodule

// File: tb/tb_program_rom_loader.sv
// Bench for program_rom_loader: cycle-level vector table plus randomized
// download sessions scored against a byte-level model of the image load.
module tb_program_rom_loader;

    // Smaller blocks keep full-image sessions short; behaviour is size-independent.
    localparam int AW  = 10;
    localparam int NR  = 5;
    localparam int IMG = NR << AW;

    logic           clk = 1'b0;
    logic           resetn;
    logic           ioctl_download;
    logic [7:0]     ioctl_index;
    logic [24:0]    ioctl_addr;
    logic [7:0]     ioctl_dout;
    logic           ioctl_wr;
    logic           ioctl_wait;
    logic [AW-1:0]  rom_wr_addr;
    logic [7:0]     rom_wr_data;
    logic [NR-1:0]  rom_we;
    logic           cpu_hold;
    logic           load_done;
    logic           load_error;
    logic [15:0]    checksum;

    program_rom_loader #(
        .ROM_AW(AW),
        .NUM_ROMS(NR),
        .LOAD_INDEX(8'd0)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .ioctl_wr(ioctl_wr),
        .ioctl_wait(ioctl_wait),
        .rom_wr_addr(rom_wr_addr),
        .rom_wr_data(rom_wr_data),
        .rom_we(rom_we),
        .cpu_hold(cpu_hold),
        .load_done(load_done),
        .load_error(load_error),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Byte-level model of one download session.
    typedef struct {
        logic [NR-1:0] we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t         exp_q[$];
    logic        m_busy;
    logic        m_err;
    int          m_count;
    logic [15:0] m_sum;
    int          chip_cnt[NR];
    logic        mon_en;

    task automatic model_clear();
        m_busy  = 1'b0;
        m_err   = 1'b0;
        m_count = 0;
        m_sum   = 16'h0000;
        exp_q.delete();
        for (int i = 0; i < NR; i++) chip_cnt[i] = 0;
    endtask

    task automatic model_step(input logic wr, input logic [24:0] a, input logic [7:0] d);
        wr_t w;
        int  ai;
        ai = int'(a);
        if (!wr) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_err  = 1'b1;
            m_busy = 1'b0;
        end else if (ai < IMG) begin
            w.we   = NR'(1 << (ai / (1 << AW)));
            w.addr = AW'(ai % (1 << AW));
            w.data = d;
            exp_q.push_back(w);
            m_count++;
            m_sum  = m_sum + {8'h00, d};
            m_busy = 1'b1;
        end else begin
            m_err  = 1'b1;
            m_busy = 1'b0;
        end
    endtask

    // Write monitor: every ROM write must match the next one the model predicts.
    always @(negedge clk) begin
        if (mon_en && (rom_we != '0)) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: rom_we=%b addr=%0h data=%0h, no write expected",
                         rom_we, rom_wr_addr, rom_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_we", 32'(rom_we), 32'(e.we));
                check("wr_addr", 32'(rom_wr_addr), 32'(e.addr));
                check("wr_data", 32'(rom_wr_data), 32'(e.data));
            end
            for (int i = 0; i < NR; i++) if (rom_we[i]) chip_cnt[i]++;
        end
    end

    task automatic cycle(input logic dl, input logic [7:0] idx, input logic wr,
                         input logic [24:0] a, input logic [7:0] d);
        ioctl_download = dl;
        ioctl_index    = idx;
        ioctl_wr       = wr;
        ioctl_addr     = a;
        ioctl_dout     = d;
        if (dl && (idx == 8'd0)) model_step(wr, a, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycle(input logic dl);
        cycle(dl, 8'd0, 1'b0, 25'd0, 8'd0);
    endtask

    task automatic send(input int a, input logic [7:0] d, input int gap);
        cycle(1'b1, 8'd0, 1'b1, 25'(a), d);
        repeat (gap) idle_cycle(1'b1);
    endtask

    task automatic do_reset(input string tag);
        resetn   = 1'b0;
        ioctl_wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_we"}, 32'(rom_we), 32'd0);
        check({tag, "_wait"}, 32'(ioctl_wait), 32'd0);
        check({tag, "_addr"}, 32'(rom_wr_addr), 32'd0);
        check({tag, "_data"}, 32'(rom_wr_data), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_err"}, 32'(load_error), 32'd0);
        check({tag, "_sum"}, 32'(checksum), 32'd0);
        resetn = 1'b1;
        model_clear();
    endtask

    task automatic start_session();
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        model_clear();
    endtask

    task automatic end_session(input string tag);
        logic exp_err;
        check({tag, "_hold_during"}, 32'(cpu_hold), 32'd1);
        repeat (3) idle_cycle(1'b0);
        exp_err = m_err || (m_count != IMG);
        check({tag, "_done"}, 32'(load_done), 32'(!exp_err));
        check({tag, "_err"}, 32'(load_error), 32'(exp_err));
        check({tag, "_hold_after"}, 32'(cpu_hold), 32'd0);
        check({tag, "_wait"}, 32'(ioctl_wait), 32'd0);
        check({tag, "_sum"}, 32'(checksum), 32'(m_sum));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic          dl;
        logic [7:0]    idx;
        logic          wr;
        logic [24:0]   addr;
        logic [7:0]    din;
        logic [NR-1:0] we;
        logic [AW-1:0] waddr;
        logic [7:0]    wdata;
        logic          busy;
        logic          hold;
        logic          done;
        logic          err;
        logic [15:0]   sum;
    } vec_t;

    vec_t vt[14];
    int   order[IMG];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the test sequence ended");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           dl   idx    wr    addr        din    we        waddr    wdata  busy  hold  done  err   sum
        vt[0]  = '{1'b1, 8'd0, 1'b0, 25'h0000, 8'h00, 5'b00000, 10'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vt[1]  = '{1'b1, 8'd0, 1'b1, 25'h0C05, 8'hA5, 5'b01000, 10'h005, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        vt[2]  = '{1'b1, 8'd0, 1'b0, 25'h0000, 8'h00, 5'b00000, 10'h005, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00A5};
        vt[3]  = '{1'b1, 8'd0, 1'b1, 25'h0000, 8'h11, 5'b00001, 10'h000, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00A5};
        vt[4]  = '{1'b1, 8'd0, 1'b1, 25'h0001, 8'h22, 5'b00000, 10'h000, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00B6};
        vt[5]  = '{1'b1, 8'd0, 1'b1, 25'hA000, 8'h33, 5'b00000, 10'h000, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00B6};
        vt[6]  = '{1'b1, 8'd0, 1'b1, 25'h13FF, 8'h44, 5'b10000, 10'h3FF, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00B6};
        vt[7]  = '{1'b0, 8'd0, 1'b0, 25'h0000, 8'h00, 5'b00000, 10'h3FF, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00FA};
        vt[8]  = '{1'b0, 8'd0, 1'b0, 25'h0000, 8'h00, 5'b00000, 10'h3FF, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00FA};
        vt[9]  = '{1'b1, 8'd1, 1'b1, 25'h0000, 8'h55, 5'b00000, 10'h3FF, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00FA};
        vt[10] = '{1'b1, 8'd0, 1'b0, 25'h0000, 8'h00, 5'b00000, 10'h3FF, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00FA};
        vt[11] = '{1'b1, 8'd0, 1'b0, 25'h0000, 8'h00, 5'b00000, 10'h3FF, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vt[12] = '{1'b1, 8'd0, 1'b1, 25'h1400, 8'h66, 5'b00000, 10'h3FF, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
        vt[13] = '{1'b0, 8'd0, 1'b0, 25'h0000, 8'h00, 5'b00000, 10'h3FF, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};

        resetn         = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        mon_en         = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset("reset");

        // Foreign image index: nothing may be written and the CPU stays held.
        mon_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 8'd1, 1'(i % 2), 25'(i), 8'(i));
            check("idx1_hold", 32'(cpu_hold), 32'd1);
        end
        idle_cycle(1'b0);
        check("idx1_we", 32'(rom_we), 32'd0);
        check("idx1_done", 32'(load_done), 32'd0);
        check("idx1_err", 32'(load_error), 32'd0);

        mon_en = 1'b0;
        for (int i = 0; i < 14; i++) begin
            ioctl_download = vt[i].dl;
            ioctl_index    = vt[i].idx;
            ioctl_wr       = vt[i].wr;
            ioctl_addr     = vt[i].addr;
            ioctl_dout     = vt[i].din;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_we", i), 32'(rom_we), 32'(vt[i].we));
            check($sformatf("vec%0d_addr", i), 32'(rom_wr_addr), 32'(vt[i].waddr));
            check($sformatf("vec%0d_data", i), 32'(rom_wr_data), 32'(vt[i].wdata));
            check($sformatf("vec%0d_wait", i), 32'(ioctl_wait), 32'(vt[i].busy));
            check($sformatf("vec%0d_hold", i), 32'(cpu_hold), 32'(vt[i].hold));
            check($sformatf("vec%0d_done", i), 32'(load_done), 32'(vt[i].done));
            check($sformatf("vec%0d_err", i), 32'(load_error), 32'(vt[i].err));
            check($sformatf("vec%0d_sum", i), 32'(checksum), 32'(vt[i].sum));
        end
        ioctl_wr = 1'b0;
        mon_en   = 1'b1;

        // Full image in order, byte value = low address byte.
        start_session();
        for (int i = 0; i < IMG; i++) send(i, 8'(i), int'($urandom_range(1, 2)));
        end_session("full");
        for (int c = 0; c < NR; c++) check($sformatf("full_chip%0d_count", c), 32'(chip_cnt[c]), 32'(1 << AW));

        // Image cut short after one block.
        start_session();
        for (int i = 0; i < (1 << AW); i++) send(i, 8'($urandom), 1);
        end_session("short");

        // Reset mid-image, then a complete load in shuffled order.
        start_session();
        for (int i = 0; i < 600; i++) send(i, 8'($urandom), 1);
        do_reset("midreset");
        start_session();
        for (int i = 0; i < IMG; i++) order[i] = i;
        for (int i = IMG - 1; i > 0; i--) begin
            int j;
            int t;
            j        = int'($urandom_range(0, i));
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < IMG; i++) send(order[i], 8'($urandom), int'($urandom_range(1, 3)));
        end_session("reload");
        for (int c = 0; c < NR; c++) check($sformatf("reload_chip%0d_count", c), 32'(chip_cnt[c]), 32'(1 << AW));

        // Unruly host: random strobes, some out of range, some while busy.
        start_session();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                int a;
                if ($urandom_range(0, 4) != 0) a = int'($urandom_range(0, IMG - 1));
                else a = IMG + int'($urandom_range(0, 40000));
                cycle(1'b1, 8'd0, 1'b1, 25'(a), 8'($urandom));
            end else begin
                idle_cycle(1'b1);
            end
        end
        end_session("random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
